// File: rtl/enc_cnt_capture.sv
// rtl/enc_cnt_capture.sv - two-channel encoder count capture into a tagged FWFT FIFO
module enc_cnt_capture #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_ARM,
    input  logic          I_CLR,
    input  logic          I_STB0,
    input  logic          I_STB1,
    input  logic [63:0]   I_CNT0,
    input  logic [63:0]   I_CNT1,
    input  logic          I_OVF0,
    input  logic          I_OVF1,
    input  logic          I_READY,
    output logic          O_VALID,
    output logic [63:0]   O_DATA,
    output logic          O_CH,
    output logic          O_OVF,
    output logic [AW:0]   O_LEVEL,
    output logic          O_FULL,
    output logic          O_EMPTY,
    output logic [15:0]   O_DROP
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic          prev0, prev1;
    logic [1:0]    slot_full;
    logic [64:0]   slot0, slot1;
    logic          last_grant;
    logic [65:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [15:0]   drop_cnt;

    logic        ev0, ev1, fifo_full, fifo_empty;
    logic        push, pop, contend, gnt_ch, gnt0, gnt1, drop0, drop1;
    logic [16:0] drop_sum;
    logic [15:0] drop_next;
    logic [65:0] wdata;

    assign ev0        = I_STB0 & ~prev0 & I_ARM;
    assign ev1        = I_STB1 & ~prev1 & I_ARM;
    assign fifo_full  = (level == FULL_LVL);
    assign fifo_empty = (level == '0);

    // Round-robin pointer only moves on contended grants, so after a
    // contended pair the next contended pair starts with the other channel.
    assign contend = &slot_full;
    assign gnt_ch  = contend ? ~last_grant : slot_full[1];
    assign push    = (|slot_full) & ~fifo_full;
    assign gnt0    = push & ~gnt_ch;
    assign gnt1    = push & gnt_ch;
    assign pop     = ~fifo_empty & I_READY;
    assign wdata   = gnt_ch ? {1'b1, slot1} : {1'b0, slot0};

    assign drop0     = ev0 & slot_full[0] & ~gnt0;
    assign drop1     = ev1 & slot_full[1] & ~gnt1;
    assign drop_sum  = {1'b0, drop_cnt} + 17'(drop0) + 17'(drop1);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev0      <= 1'b0;
            prev1      <= 1'b0;
            slot_full  <= 2'b00;
            slot0      <= '0;
            slot1      <= '0;
            last_grant <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_cnt   <= '0;
        end else begin
            prev0 <= I_STB0;
            prev1 <= I_STB1;
            if (I_CLR) begin
                slot_full <= 2'b00;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                drop_cnt  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (contend)
                        last_grant <= gnt_ch;
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   level <= level + (AW + 1)'(1);
                    2'b01:   level <= level - (AW + 1)'(1);
                    default: level <= level;
                endcase
                // A granted slot may be refilled by a new event in the same cycle.
                slot_full[0] <= ev0 | (slot_full[0] & ~gnt0);
                slot_full[1] <= ev1 | (slot_full[1] & ~gnt1);
                if (ev0 & (~slot_full[0] | gnt0))
                    slot0 <= {I_OVF0, I_CNT0};
                if (ev1 & (~slot_full[1] | gnt1))
                    slot1 <= {I_OVF1, I_CNT1};
                drop_cnt <= drop_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push & ~RST & ~I_CLR)
            mem[wr_ptr] <= wdata;
    end

    assign O_VALID = ~fifo_empty;
    assign O_EMPTY = fifo_empty;
    assign O_FULL  = fifo_full;
    assign O_LEVEL = level;
    assign O_DROP  = drop_cnt;
    assign {O_CH, O_OVF, O_DATA} = fifo_empty ? 66'd0 : mem[rd_ptr];

endmodule
